// File: rtl/mem_access_pkg.sv
// Shared constants for the memory-access stage: datapath width, ctrl-word
// instruction classes, load/store funct3 codes and the MEM FSM state type.
// Ports: none (package). Also hosts the access-size mask helper.
package mem_access_pkg;

    localparam int REG_WIDTH = 64;
    localparam int XLEN      = REG_WIDTH;
    localparam int STRB_W    = XLEN / 8;

    // Instruction class carried in ctrl[6:3]
    localparam logic [3:0] CTRL_ALU       = 4'd1;
    localparam logic [3:0] CTRL_ACCESS_I  = 4'd2;   // load
    localparam logic [3:0] CTRL_ACCESS_S  = 4'd3;   // store
    localparam logic [3:0] CTRL_BRANCH    = 4'd4;
    localparam logic [3:0] CTRL_EXCEPTION = 4'd15;

    // Load funct3 (stores reuse codes 0..3 for SB/SH/SW/SD)
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // Access size minus one, from funct3[1:0] (byte/half/word/double)
    function automatic logic [2:0] size_mask(input logic [1:0] size_code);
        case (size_code)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_store_align.sv
// Byte-lane alignment: store strobes/data shifted to the lane offset, and load
// data extracted from the 8-byte read word with sign or zero extension.
// Purely combinational, zero latency, no backpressure.
// Ports: st_size_i/st_off_i/st_data_i -> st_wstrb_o/st_wdata_o;
//        ld_funct3_i/ld_off_i/ld_rdata_i -> ld_data_o.
module load_store_align
    import mem_access_pkg::*;
(
    input  logic [1:0]        st_size_i,
    input  logic [2:0]        st_off_i,
    input  logic [XLEN-1:0]   st_data_i,
    output logic [STRB_W-1:0] st_wstrb_o,
    output logic [XLEN-1:0]   st_wdata_o,
    input  logic [2:0]        ld_funct3_i,
    input  logic [2:0]        ld_off_i,
    input  logic [XLEN-1:0]   ld_rdata_i,
    output logic [XLEN-1:0]   ld_data_o
);

    logic [STRB_W-1:0] base_strb;
    logic [XLEN-1:0]   ld_shifted;

    always_comb begin
        case (st_size_i)
            2'd0:    base_strb = 8'h01;
            2'd1:    base_strb = 8'h03;
            2'd2:    base_strb = 8'h0F;
            default: base_strb = 8'hFF;
        endcase
        st_wstrb_o = base_strb << st_off_i;
        st_wdata_o = st_data_i << {st_off_i, 3'b000};
    end

    // Bring the addressed byte down to lane 0, then extend
    assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        case (ld_funct3_i)
            F3_LB:   ld_data_o = {{56{ld_shifted[7]}},  ld_shifted[7:0]};
            F3_LH:   ld_data_o = {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_LW:   ld_data_o = {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            F3_LBU:  ld_data_o = {56'd0, ld_shifted[7:0]};
            F3_LHU:  ld_data_o = {48'd0, ld_shifted[15:0]};
            F3_LWU:  ld_data_o = {32'd0, ld_shifted[31:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: registers EX results into WB, runs loads/stores on the
// dmem req/ack bus. Latency 1 for non-memory ops; memory ops take issue cycle
// plus WAIT until ack. stall_o holds EX while an access is issuing or pending.
// Ports: clk_sys_i/rst_sys_i (async, active-high); EX inputs (ex_valid_i,
//   result_i, store_data_i, rd_i, ctrl_i, funct3_i, EX_ena_forwarding_i);
//   dmem bus (req/we/addr/wdata/wstrb out, ack/rdata in); WB and MEM
//   forwarding outputs; stall_o.
// Build option MEM_MISALIGN_CHECK_EN: misaligned accesses become an exception
//   bubble to WB instead of a truncated-address access.
module mem_access
    import mem_access_pkg::*;
(
    input  logic              clk_sys_i,
    input  logic              rst_sys_i,
    input  logic              ex_valid_i,
    input  logic [XLEN-1:0]   result_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [4:0]        rd_i,
    input  logic [7:0]        ctrl_i,
    input  logic [2:0]        funct3_i,
    input  logic              EX_ena_forwarding_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [STRB_W-1:0] dmem_wstrb_o,
    input  logic              dmem_ack_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic [XLEN-1:0]   result_o,
    output logic [4:0]        rd_o,
    output logic [7:0]        ctrl_o,
    output logic              MEM_ena_forwarding_o,
    output logic [4:0]        MEM_addr_forwarding_o,
    output logic [XLEN-1:0]   MEM_data_forwarding_o
);

    logic [3:0]        ctrl_class;
    logic              is_store;
    logic              is_mem;
    logic              misaligned;
    logic              issue;
    logic [2:0]        off_eff;

    mem_state_e        state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;
    logic [7:0]        ctrl_q, ctrl_d;
    logic              ena_q, ena_d;

    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [2:0]        f3_q;
    logic [2:0]        off_q;

    logic [STRB_W-1:0] st_wstrb;
    logic [XLEN-1:0]   st_wdata;
    logic [XLEN-1:0]   ld_data;

    assign ctrl_class = ctrl_i[6:3];
    assign is_store   = (ctrl_class == CTRL_ACCESS_S);
    assign is_mem     = ex_valid_i & ((ctrl_class == CTRL_ACCESS_I) | is_store);

    // Offset rounded down to the access size; a no-op for aligned accesses
    assign off_eff = result_i[2:0] & ~size_mask(funct3_i[1:0]);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = is_mem & ((result_i[2:0] & size_mask(funct3_i[1:0])) != 3'b000);
`else
    assign misaligned = 1'b0;
`endif

    load_store_align u_align (
        .st_size_i   (funct3_i[1:0]),
        .st_off_i    (off_eff),
        .st_data_i   (store_data_i),
        .st_wstrb_o  (st_wstrb),
        .st_wdata_o  (st_wdata),
        .ld_funct3_i (f3_q),
        .ld_off_i    (off_q),
        .ld_rdata_i  (dmem_rdata_i),
        .ld_data_o   (ld_data)
    );

    // Next-state and WB next values; default is a bubble into WB
    always_comb begin
        state_d  = state_q;
        stall_o  = 1'b0;
        issue    = 1'b0;
        result_d = '0;
        rd_d     = '0;
        ctrl_d   = '0;
        ena_d    = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (misaligned) begin
                    result_d = result_i;
                    rd_d     = rd_i;
                    ctrl_d   = {ctrl_i[7], CTRL_EXCEPTION, ctrl_i[2:0]};
                end else if (is_mem) begin
                    stall_o = 1'b1;
                    issue   = 1'b1;
                    state_d = MEM_WAIT;
                end else if (ex_valid_i) begin
                    result_d = result_i;
                    rd_d     = rd_i;
                    ctrl_d   = ctrl_i;
                    ena_d    = EX_ena_forwarding_i;
                end
            end
            MEM_WAIT: begin
                // EX is held by stall, so rd/ctrl/result inputs still describe this access
                if (dmem_ack_i) begin
                    state_d  = MEM_IDLE;
                    result_d = we_q ? result_i : ld_data;
                    rd_d     = rd_i;
                    ctrl_d   = ctrl_i;
                    ena_d    = EX_ena_forwarding_i;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q  <= MEM_IDLE;
            result_q <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
            ena_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
            ena_q    <= ena_d;
        end
    end

    // Bus fields captured at issue and held stable through WAIT
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else if (issue) begin
            we_q    <= is_store;
            addr_q  <= {result_i[XLEN-1:3], 3'b000};
            wdata_q <= is_store ? st_wdata : '0;
            wstrb_q <= st_wstrb;
            f3_q    <= funct3_i;
            off_q   <= off_eff;
        end
    end

    assign dmem_req_o            = (state_q == MEM_WAIT);
    assign dmem_we_o             = we_q;
    assign dmem_addr_o           = addr_q;
    assign dmem_wdata_o          = wdata_q;
    assign dmem_wstrb_o          = wstrb_q;

    assign result_o              = result_q;
    assign rd_o                  = rd_q;
    assign ctrl_o                = ctrl_q;
    assign MEM_ena_forwarding_o  = ena_q;
    assign MEM_addr_forwarding_o = rd_q;
    assign MEM_data_forwarding_o = result_q;

endmodule
